// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract scheduler.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam int unsigned ID_W = 1;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sched_fa_cell.sv
// Decoder-based full adder: one-hot decode of {a, b, cin}, outputs ORed from minterms.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic [7:0] dec;

    always_comb begin
        dec  = 8'b0000_0001 << {a, b, cin};
        sum  = dec[1] | dec[2] | dec[4] | dec[7];
        cout = dec[3] | dec[5] | dec[6] | dec[7];
    end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial full adder between two requesters.
// Subtraction is enabled by defining SERIAL_ADD_SUB_EN; otherwise every operation is an add.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic [ID_W-1:0]  rsp_id
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic              rr_q;     // 1 = req1 wins a tie
    logic              grant0, grant1, handshake;
    logic              op_sel, op_q, carry_q;
    logic [ID_W-1:0]   id_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  a_sh, b_sh, res_q;
    logic              fa_sum, fa_cout;

`ifdef SERIAL_ADD_SUB_EN
    assign op_sel = grant1 ? req1_op : req0_op;
`else
    logic unused_op;
    assign unused_op = req0_op ^ req1_op;
    assign op_sel    = 1'b0;
`endif

    always_comb begin
        grant1     = req1_valid & (~req0_valid | rr_q);
        grant0     = req0_valid & ~grant1;
        req0_ready = ~rst & (state_q == S_IDLE) & grant0;
        req1_ready = ~rst & (state_q == S_IDLE) & grant1;
        handshake  = req0_ready | req1_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (handshake) state_d = S_RUN;
            S_RUN:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
            S_DONE: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0] ^ op_q),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_q   <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                rr_q    <= grant0;
                a_sh    <= grant1 ? req1_a : req0_a;
                b_sh    <= grant1 ? req1_b : req0_b;
                op_q    <= op_sel;
                carry_q <= op_sel;
                id_q    <= ID_W'(grant1);
                cnt_q   <= '0;
            end else if (state_q == S_RUN) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                res_q   <= {fa_sum, res_q[WIDTH-1:1]};
                carry_q <= fa_cout;
                cnt_q   <= cnt_q + CW'(1);
            end
        end
    end

    assign rsp_valid = (state_q == S_DONE);
    assign rsp_sum   = res_q;
    assign rsp_cout  = carry_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed self-checking bench: WIDTH=8 instance for scheduling, WIDTH=4 instance for a full sweep.
module tb_serial_add_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH = 8 instance
    logic       req0_valid = 0, req1_valid = 0, req0_op = 0, req1_op = 0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic       rsp_valid, rsp_cout, rsp_id;
    logic       rsp_ready = 0;
    logic [7:0] rsp_sum;

    serial_add_sched #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_id(rsp_id)
    );

    // WIDTH = 4 instance
    logic       q0_valid = 0, q1_valid = 0;
    logic       q0_ready, q1_ready;
    logic [3:0] q0_a = 0, q0_b = 0, q1_a = 0, q1_b = 0;
    logic       q_rsp_valid, q_rsp_cout, q_rsp_id;
    logic [3:0] q_rsp_sum;

    serial_add_sched #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(q0_valid), .req0_ready(q0_ready), .req0_a(q0_a), .req0_b(q0_b),
        .req0_op(1'b0),
        .req1_valid(q1_valid), .req1_ready(q1_ready), .req1_a(q1_a), .req1_b(q1_b),
        .req1_op(1'b0),
        .rsp_valid(q_rsp_valid), .rsp_ready(1'b1), .rsp_sum(q_rsp_sum), .rsp_cout(q_rsp_cout),
        .rsp_id(q_rsp_id)
    );

    // Stimulus helpers (no checking): start and end just after a rising edge.
    task automatic issue8(input logic v0, input logic v1,
                          input logic [7:0] a0, input logic [7:0] b0, input logic o0,
                          input logic [7:0] a1, input logic [7:0] b1, input logic o1,
                          output logic ok, output logic gid);
        ok = 0; gid = 0;
        req0_a = a0; req0_b = b0; req0_op = o0; req0_valid = v0;
        req1_a = a1; req1_b = b1; req1_op = o1; req1_valid = v1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gid = req1_ready;
                ok  = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic wait_rsp8(output int lat, output logic ok);
        ok = 0; lat = 0;
        while (lat < 100) begin
            @(posedge clk); lat++; #1;
            if (rsp_valid) begin ok = 1; break; end
        end
    endtask

    task automatic take_rsp8;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        req0_valid = 1; req1_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        checks++;
        if (rsp_sum !== 8'h00 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_fields: got sum=%h cout=%b id=%b want 00/0/0",
                               rsp_sum, rsp_cout, rsp_id);
        end
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_add_wrap;
        logic ok, gid, rok;
        int lat;
        issue8(1, 0, 8'hFF, 8'h01, 0, 8'h00, 8'h00, 0, ok, gid);
        checks++;
        if (ok !== 1'b1 || gid !== 1'b0) begin
            errors++; $display("FAIL add_grant: got ok=%b id=%b want 1/0", ok, gid);
        end
        wait_rsp8(lat, rok);
        checks++;
        if (rok !== 1'b1 || lat != 8) begin
            errors++; $display("FAIL add_latency: got ok=%b lat=%0d want 1/8", rok, lat);
        end
        checks++;
        if (rsp_sum !== 8'h00 || rsp_cout !== 1'b1 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL add_wrap: got sum=%h cout=%b id=%b want 00/1/0",
                               rsp_sum, rsp_cout, rsp_id);
        end
        take_rsp8();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL add_rsp_drop: got %b want 0", rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_subtract;
        logic ok, gid, rok;
        int lat;
        logic [7:0] exp_sum [2];
        logic       exp_cout [2];
        logic [7:0] va [2];
        logic [7:0] vb [2];
        va[0] = 8'd5; vb[0] = 8'd3; va[1] = 8'd3; vb[1] = 8'd5;
`ifdef SERIAL_ADD_SUB_EN
        exp_sum[0] = 8'h02; exp_cout[0] = 1'b1;
        exp_sum[1] = 8'hFE; exp_cout[1] = 1'b0;
`else
        exp_sum[0] = 8'h08; exp_cout[0] = 1'b0;
        exp_sum[1] = 8'h08; exp_cout[1] = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            issue8(0, 1, 8'h00, 8'h00, 0, va[k], vb[k], 1, ok, gid);
            wait_rsp8(lat, rok);
            checks++;
            if (ok !== 1'b1 || rok !== 1'b1 || lat != 8) begin
                errors++; $display("FAIL sub_handshake_%0d: got ok=%b rok=%b lat=%0d want 1/1/8",
                                   k, ok, rok, lat);
            end
            checks++;
            if (rsp_sum !== exp_sum[k] || rsp_cout !== exp_cout[k] || rsp_id !== 1'b1) begin
                errors++; $display("FAIL sub_result_%0d: got sum=%h cout=%b id=%b want %h/%b/1",
                                   k, rsp_sum, rsp_cout, rsp_id, exp_sum[k], exp_cout[k]);
            end
            take_rsp8();
        end
    endtask

    task automatic test_round_robin;
        logic order [$];
        int both_hi = 0;
        logic [3:0] got = '0;
        req0_a = 8'h01; req0_b = 8'h01; req0_op = 0;
        req1_a = 8'h02; req1_b = 8'h02; req1_op = 0;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        for (int c = 0; c < 200 && order.size() < 4; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_hi++;
            if (req0_ready) order.push_back(1'b0);
            else if (req1_ready) order.push_back(1'b1);
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        repeat (12) @(posedge clk);
        #1 rsp_ready = 0;
        for (int i = 0; i < 4; i++) got[i] = (i < order.size()) ? order[i] : 1'bx;
        checks++;
        if (order.size() != 4 || got !== 4'b1010) begin
            errors++; $display("FAIL rr_order: got n=%0d order(lsb first)=%b want 4/1010",
                               order.size(), got);
        end
        checks++;
        if (both_hi != 0) begin
            errors++; $display("FAIL rr_onehot: got %0d cycles with both ready want 0", both_hi);
        end
    endtask

    task automatic test_back_pressure;
        logic ok, gid, rok;
        int lat;
        int bad = 0;
        issue8(1, 0, 8'h12, 8'h34, 0, 8'h00, 8'h00, 0, ok, gid);
        req1_a = 8'h10; req1_b = 8'h20; req1_op = 0; req1_valid = 1;
        wait_rsp8(lat, rok);
        checks++;
        if (ok !== 1'b1 || gid !== 1'b0 || rok !== 1'b1 || lat != 8) begin
            errors++; $display("FAIL bp_start: got ok=%b id=%b rok=%b lat=%0d want 1/0/1/8",
                               ok, gid, rok, lat);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_sum !== 8'h46 || rsp_cout !== 1'b0 ||
                rsp_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        rsp_ready = 1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++; $display("FAIL bp_same_cycle_accept: got ready1=%b want 0", req1_ready);
        end
        @(posedge clk); #1;
        rsp_ready = 0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_next_accept: got ready1=%b valid=%b want 1/0",
                               req1_ready, rsp_valid);
        end
        @(posedge clk); #1;
        req1_valid = 0;
        wait_rsp8(lat, rok);
        checks++;
        if (rok !== 1'b1 || rsp_sum !== 8'h30 || rsp_cout !== 1'b0 || rsp_id !== 1'b1) begin
            errors++; $display("FAIL bp_second: got ok=%b sum=%h cout=%b id=%b want 1/30/0/1",
                               rok, rsp_sum, rsp_cout, rsp_id);
        end
        take_rsp8();
    endtask

    task automatic test_reset_mid_run;
        logic ok, gid, rok;
        int lat;
        // req0 alone leaves the tie-break favouring req1 unless reset clears it
        issue8(1, 0, 8'hAA, 8'h11, 0, 8'h00, 8'h00, 0, ok, gid);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1;
        req0_a = 8'h40; req0_b = 8'h05; req0_op = 0;
        req1_a = 8'h77; req1_b = 8'h01; req1_op = 0;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_rsp: got %b want 0", rsp_valid);
        end
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_grant: got %b%b want ready0 only",
                               req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_rsp8(lat, rok);
        checks++;
        if (rok !== 1'b1 || lat != 8 || rsp_sum !== 8'h45 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL rst_mid_next_op: got ok=%b lat=%0d sum=%h id=%b want 1/8/45/0",
                               rok, lat, rsp_sum, rsp_id);
        end
        take_rsp8();
    endtask

    task automatic test_sweep4;
        logic [4:0] exp;
        logic done;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                q0_a = 4'(a); q0_b = 4'(b); q0_valid = 1;
                exp = 5'(a + b);
                done = 0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (q0_ready) begin
                        @(posedge clk); #1;
                        q0_valid = 0;
                    end else if (!q0_valid && q_rsp_valid) begin
                        done = 1;
                        break;
                    end
                end
                q0_valid = 0;
                checks++;
                if (!done || {q_rsp_cout, q_rsp_sum} !== exp || q_rsp_id !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep a=%0d b=%0d: got done=%b cout=%b sum=%h id=%b want %b/%h/0",
                             a, b, done, q_rsp_cout, q_rsp_sum, q_rsp_id, exp[4], exp[3:0]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_subtract();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_run();
        test_sweep4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Bit-serial add/subtract scheduler that shares a single decoder-based full-adder cell between two requesters. It arbitrates round-robin between the requesters and latches the winner's operands. It then sequences the cell LSB-first for WIDTH cycles, keeping the carry in a register, and returns the result on a valid/ready response port tagged with the requester ID. It sits between operand producers and the result consumer wherever area matters more than add latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  1  0 = add, 1 = subtract (a - b); used only with the macro in Configuration
- req1_valid, req1_ready, req1_a, req1_b, req1_op  as above, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_sum  out  WIDTH  result, modulo 2^WIDTH
- rsp_cout  out  1  final carry; for subtract, 1 = no borrow (a >= b)
- rsp_id  out  1  requester that issued the result

## Operation
- FSM states are S_IDLE, S_RUN and S_DONE. Reset enters S_IDLE.
- **S_IDLE:**
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester not granted last is granted. The pointer resets to favour req0.
  - reqN_ready = (state == S_IDLE) & grantN. It is combinational from both valids. At most one ready is high.
  - On handshake:
    - latch a, b, op and id
    - carry <= op_eff (op_eff = op with the macro, else 0)
    - bit counter <= 0
    - update the pointer
    - go to S_RUN
- **S_RUN:** each cycle, the fa_cell inputs are a_sh[0], b_sh[0] ^ op_eff and carry.
  - The cell's sum shifts into the MSB of the result register, which shifts right.
  - a_sh and b_sh shift right.
  - carry <= cell cout.
  - The counter increments.
  - After the cycle with counter == WIDTH-1, go to S_DONE.
- **S_DONE:**
  - rsp_valid = 1.
  - rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to S_IDLE.
- Request inputs are ignored outside S_IDLE. Both readies are 0 in S_RUN and S_DONE.
- The arithmetic is exact two's complement at WIDTH bits. Overflow is not flagged and is visible only through rsp_cout.

## Timing
- **Reset values:**
  - req0_ready = 0 and req1_ready = 0 while rst is high
  - rsp_valid = 0
  - rsp_sum = 0, rsp_cout = 0, rsp_id = 0
  - round-robin pointer favours req0
- **Latency:** if a handshake occurs at edge E, rsp_valid rises after edge E+WIDTH.
- **Throughput:** at least WIDTH+2 cycles per operation (WIDTH in S_RUN, at least 1 in S_DONE, 1 in S_IDLE).
- **Back-pressure:** the block may stay in S_DONE indefinitely. No new grant is issued until the response is taken.
- **Simultaneous rsp handshake and new request:** the new request is not accepted in the same cycle. It is accepted on the next S_IDLE cycle.
- **Reset mid-operation:** the in-flight operation is discarded and no response is produced. The block is in S_IDLE on the cycle after rst deasserts.
- A requester may drop valid before it is granted. No grant is issued to a requester whose valid is low.

## Configuration
- The macro is SERIAL_ADD_SUB_EN.
- **With the macro defined:**
  - reqN_op selects subtraction.
  - b bits are inverted and the initial carry is 1.
- **Without it:**
  - the reqN_op inputs remain as ports but are ignored
  - op_eff = 0 and every operation is an add

## Structure
- **Package serial_add_pkg** holds:
  - the state enum (S_IDLE, S_RUN, S_DONE)
  - the counter-width helper, $clog2(WIDTH)
  - the requester-ID width constant (1)
- **Sub-module fa_cell** is purely combinational.
  - It performs a 3:8 one-hot decode of {a, b, cin}.
  - sum = minterms 1 | 2 | 4 | 7.
  - cout = minterms 3 | 5 | 6 | 7.
  - It is instantiated once, and it is the only adder in the block.

## Test plan
- **Add with wrap:** WIDTH=8, req0 a=8'hFF, b=8'h01, add.
  - Expect rsp_sum=8'h00, rsp_cout=1, rsp_id=0.
  - rsp_valid rises exactly 8 edges after the handshake.
- **Subtract (macro defined):** WIDTH=8.
  - req1 a=5, b=3: expect rsp_sum=2, rsp_cout=1, rsp_id=1.
  - Then req1 a=3, b=5: expect rsp_sum=8'hFE, rsp_cout=0.
  - Without the macro, the same op=1 stimuli give 8 and 8 (add).
- **Round-robin:** hold both valids high for 4 operations and keep rsp_ready=1.
  - Expect grants in the order 0, 1, 0, 1.
  - At most one ready is high in any cycle.
- **Back-pressure:** keep rsp_ready=0 for 20 cycles after rsp_valid rises.
  - Outputs stay stable and both readies stay 0.
  - On rsp_ready=1, the next request is accepted one cycle later.
- **Reset mid-run:** assert rst at RUN cycle 3 of 8.
  - Expect no response, rsp_valid=0, and the next operation granted to req0 when both are valid.
- **Exhaustive sweep:** WIDTH=4, all 256 (a, b) pairs on req0.
  - Each result must equal a+b modulo 16, with the carry equal to bit 4 of the sum.
